// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel frame controller.
// Holds the pixel width, the default frame geometry and datapath latency,
// and the controller FSM state type.
package sobel_pkg;

    localparam int unsigned PIX_W         = 8;
    localparam int unsigned DEF_IMG_W     = 64;
    localparam int unsigned DEF_IMG_H     = 64;
    localparam int unsigned DEF_SOBEL_LAT = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/sobel_linebuf.sv
// Two-row line buffer feeding the Sobel column interface.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset (output registers only)
//   i_we           : pixel accepted this cycle
//   i_addr         : column of the accepted pixel
//   i_din          : accepted pixel
//   o_a00/a01/a02  : registered column (row r-2, row r-1, row r)
module sobel_linebuf #(
    parameter int unsigned IMG_W  = 64,
    parameter int unsigned PIX_W  = 8,
    localparam int unsigned ADDR_W = $clog2(IMG_W)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [PIX_W-1:0]  i_din,
    output logic [PIX_W-1:0]  o_a00,
    output logic [PIX_W-1:0]  o_a01,
    output logic [PIX_W-1:0]  o_a02
);

    logic [PIX_W-1:0] r_lb0 [IMG_W];
    logic [PIX_W-1:0] r_lb1 [IMG_W];

    // Row shift on write: lb0 takes the older row, lb1 the new pixel.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_lb0[i_addr] <= r_lb1[i_addr];
            r_lb1[i_addr] <= i_din;
        end
    end

    // Column registers capture the pre-write contents alongside the new pixel.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_a00 <= '0;
            o_a01 <= '0;
            o_a02 <= '0;
        end else if (i_we) begin
            o_a00 <= r_lb0[i_addr];
            o_a01 <= r_lb1[i_addr];
            o_a02 <= i_din;
        end
    end

endmodule

// File: rtl/sobel_ctrl.sv
// Frame controller for a streaming 3x3 Sobel datapath.
// Accepts a raster pixel stream, presents 3-pixel columns to the datapath,
// tags interior results and frames them with res_vld/res_last/done.
// Ports:
//   CLOCK, RESET            : clock, async active-low reset
//   start                   : frame start pulse (ignored while busy)
//   pix_in/pix_vld/pix_rdy  : pixel stream handshake
//   input_row_a00..a02      : column to datapath, col_en marks a new column
//   sobel_ret/res_out       : datapath result and its pass-through
//   res_vld/res_last        : interior result valid / last of frame
//   busy/done/err           : status, end-of-frame pulse, sticky stall error
module sobel_ctrl #(
    parameter int unsigned IMG_W     = sobel_pkg::DEF_IMG_W,
    parameter int unsigned IMG_H     = sobel_pkg::DEF_IMG_H,
    parameter int unsigned PIX_W     = sobel_pkg::PIX_W,
    parameter int unsigned SOBEL_LAT = sobel_pkg::DEF_SOBEL_LAT
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             start,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_vld,
    output logic             pix_rdy,
    output logic [PIX_W-1:0] input_row_a00,
    output logic [PIX_W-1:0] input_row_a01,
    output logic [PIX_W-1:0] input_row_a02,
    output logic             col_en,
    input  logic [PIX_W-1:0] sobel_ret,
    output logic [PIX_W-1:0] res_out,
    output logic             res_vld,
    output logic             res_last,
    output logic             busy,
    output logic             done,
    output logic             err
);

    import sobel_pkg::*;

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned DRN_W = $clog2(SOBEL_LAT + 1);

    state_t r_state, w_state_nxt;

    logic [COL_W-1:0]     r_col;
    logic [ROW_W-1:0]     r_row;
    logic [DRN_W-1:0]     r_drain;
    logic [SOBEL_LAT-1:0] r_vld_sr;
    logic [SOBEL_LAT-1:0] r_last_sr;

    logic r_pix_rdy, r_col_en, r_res_vld, r_res_last, r_busy, r_done, r_err;
    logic w_pix_rdy_nxt, w_busy_nxt, w_done_nxt;
    logic w_accept, w_col_last, w_row_last, w_start_go, w_interior, w_frame_last;

    assign w_accept     = pix_vld && r_pix_rdy;
    assign w_col_last   = (r_col == COL_W'(IMG_W - 1));
    assign w_row_last   = (r_row == ROW_W'(IMG_H - 1));
    assign w_start_go   = (r_state == ST_IDLE) && start;
    assign w_interior   = w_accept && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
    assign w_frame_last = w_accept && w_row_last && w_col_last;

    // State register
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and next registered status outputs
    always_comb begin
        w_state_nxt   = r_state;
        w_pix_rdy_nxt = 1'b0;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_FILL;
            ST_FILL:  if (w_accept && w_col_last && (r_row == ROW_W'(1))) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_frame_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (r_drain == DRN_W'(SOBEL_LAT)) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        w_pix_rdy_nxt = (w_state_nxt == ST_FILL) || (w_state_nxt == ST_RUN);
        w_busy_nxt    = (w_state_nxt != ST_IDLE);
        w_done_nxt    = (w_state_nxt == ST_DONE);
    end

    // Raster position of the next pixel to be accepted
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_start_go) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Drain cycle counter, holds zero outside DRAIN
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET)                    r_drain <= '0;
        else if (r_state == ST_DRAIN)  r_drain <= r_drain + DRN_W'(1);
        else                           r_drain <= '0;
    end

    // Interior/last tags aligned with col_en, then delayed to meet sobel_ret
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_vld_sr  <= '0;
            r_last_sr <= '0;
        end else begin
            r_vld_sr[0]  <= w_interior;
            r_last_sr[0] <= w_frame_last;
            for (int i = 1; i < int'(SOBEL_LAT); i++) begin
                r_vld_sr[i]  <= r_vld_sr[i-1];
                r_last_sr[i] <= r_last_sr[i-1];
            end
        end
    end

    // Registered status and strobes
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_pix_rdy  <= 1'b0;
            r_col_en   <= 1'b0;
            r_res_vld  <= 1'b0;
            r_res_last <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_pix_rdy  <= w_pix_rdy_nxt;
            r_col_en   <= w_accept && (r_state == ST_RUN);
            r_res_vld  <= r_vld_sr[SOBEL_LAT-1];
            r_res_last <= r_last_sr[SOBEL_LAT-1];
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Sticky error: a bubble inside a row; cleared only by an accepted start
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_err <= 1'b0;
        end else if (w_start_go) begin
            r_err <= 1'b0;
        end else if (((r_state == ST_FILL) || (r_state == ST_RUN)) && !pix_vld
                     && (r_col != '0)) begin
            r_err <= 1'b1;
        end
    end

    sobel_linebuf #(
        .IMG_W (IMG_W),
        .PIX_W (PIX_W)
    ) u_linebuf (
        .i_clk   (CLOCK),
        .i_rst_n (RESET),
        .i_we    (w_accept),
        .i_addr  (r_col),
        .i_din   (pix_in),
        .o_a00   (input_row_a00),
        .o_a01   (input_row_a01),
        .o_a02   (input_row_a02)
    );

    assign pix_rdy  = r_pix_rdy;
    assign col_en   = r_col_en;
    assign res_out  = sobel_ret;
    assign res_vld  = r_res_vld;
    assign res_last = r_res_last;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_sobel_ctrl.sv
// Self-checking bench for sobel_ctrl (8x6 frame, latency 3).
// A stub datapath sums each column and delays it SOBEL_LAT cycles; the
// reference model predicts every result from the stored image.
module tb_sobel_ctrl;

    localparam int unsigned IMG_W     = 8;
    localparam int unsigned IMG_H     = 6;
    localparam int unsigned PIX_W     = 8;
    localparam int unsigned SOBEL_LAT = 3;
    localparam int unsigned N_VLD     = (IMG_W - 2) * (IMG_H - 2);
    localparam int unsigned N_COL     = (IMG_H - 2) * IMG_W;

    logic             CLOCK = 1'b0;
    logic             RESET = 1'b0;
    logic             start = 1'b0;
    logic [PIX_W-1:0] pix_in = '0;
    logic             pix_vld = 1'b0;
    logic             pix_rdy;
    logic [PIX_W-1:0] a00, a01, a02;
    logic             col_en;
    logic [PIX_W-1:0] sobel_ret;
    logic [PIX_W-1:0] res_out;
    logic             res_vld, res_last, busy, done, err;

    sobel_ctrl #(
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .PIX_W     (PIX_W),
        .SOBEL_LAT (SOBEL_LAT)
    ) dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .start         (start),
        .pix_in        (pix_in),
        .pix_vld       (pix_vld),
        .pix_rdy       (pix_rdy),
        .input_row_a00 (a00),
        .input_row_a01 (a01),
        .input_row_a02 (a02),
        .col_en        (col_en),
        .sobel_ret     (sobel_ret),
        .res_out       (res_out),
        .res_vld       (res_vld),
        .res_last      (res_last),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 CLOCK = ~CLOCK;

    // Stub datapath: column sum, SOBEL_LAT-stage pipeline
    logic [PIX_W-1:0] dp_pipe [SOBEL_LAT];
    always @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < int'(SOBEL_LAT); i++) dp_pipe[i] <= '0;
        end else begin
            dp_pipe[0] <= a00 + a01 + a02;
            for (int i = 1; i < int'(SOBEL_LAT); i++) dp_pipe[i] <= dp_pipe[i-1];
        end
    end
    assign sobel_ret = dp_pipe[SOBEL_LAT-1];

    typedef struct {
        int kind;        // 0 ramp row*16+col, 1 random pixels with row gaps
        int gap_row;
        int gap_col;
        int gap_len;
        bit start_mid;   // pulse start during RUN
        int abort_at;    // pixel index at which reset is asserted, -1 none
        bit exp_err;
        int exp_col;
        int exp_vld;
    } vec_t;

    vec_t vecs [7];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int last_acc = 0;
    int n_col, n_vld, n_last, n_done;
    bit mon_on    = 1'b0;
    bit chk_data  = 1'b0;
    bit cur_err   = 1'b0;
    logic [PIX_W-1:0] img [IMG_H][IMG_W];
    logic [PIX_W-1:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Per-cycle observation of the DUT against the model
    task automatic monitor();
        int r, c;
        check("res_pass", 32'(res_out), 32'(sobel_ret));
        if (col_en) begin
            if (chk_data && n_col < int'(N_COL)) begin
                r = 2 + n_col / int'(IMG_W);
                c = n_col % int'(IMG_W);
                check("a00", 32'(a00), 32'(img[r-2][c]));
                check("a01", 32'(a01), 32'(img[r-1][c]));
                check("a02", 32'(a02), 32'(img[r][c]));
            end
            n_col++;
        end
        if (res_vld) begin
            n_vld++;
            if (chk_data) begin
                if (exp_q.size() > 0) check("res_out", 32'(res_out), 32'(exp_q.pop_front()));
                else                  fail("res_vld_extra");
                check("res_last", 32'(res_last), 32'(n_vld == int'(N_VLD)));
            end
        end else begin
            check("res_last_qual", 32'(res_last), 32'(0));
        end
        if (res_last) n_last++;
        if (done) begin
            n_done++;
            if (chk_data) check("done_time", 32'(cyc), 32'(last_acc + int'(SOBEL_LAT) + 2));
            check("err_in_done", 32'(err), 32'(cur_err));
            check("rdy_in_done", 32'(pix_rdy), 32'(0));
            check("busy_in_done", 32'(busy), 32'(1));
        end
    endtask

    task automatic tick();
        @(negedge CLOCK);
        cyc++;
        if (mon_on) monitor();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pix_rdy"}, 32'(pix_rdy), 32'(0));
        check({tag, "_col_en"}, 32'(col_en), 32'(0));
        check({tag, "_res_vld"}, 32'(res_vld), 32'(0));
        check({tag, "_res_last"}, 32'(res_last), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_done"}, 32'(done), 32'(0));
        check({tag, "_err"}, 32'(err), 32'(0));
        check({tag, "_a00"}, 32'(a00), 32'(0));
        check({tag, "_a01"}, 32'(a01), 32'(0));
        check({tag, "_a02"}, 32'(a02), 32'(0));
        check({tag, "_res_out"}, 32'(res_out), 32'(0));
    endtask

    task automatic run_frame(input vec_t v);
        int r, c, gap, waitc;
        bit acc;
        for (int rr = 0; rr < int'(IMG_H); rr++)
            for (int cc = 0; cc < int'(IMG_W); cc++)
                img[rr][cc] = (v.kind == 0) ? 8'(rr * 16 + cc) : 8'($urandom_range(0, 255));
        exp_q.delete();
        for (int rr = 2; rr < int'(IMG_H); rr++)
            for (int cc = 2; cc < int'(IMG_W); cc++)
                exp_q.push_back(8'(img[rr-2][cc] + img[rr-1][cc] + img[rr][cc]));
        n_col = 0; n_vld = 0; n_last = 0; n_done = 0;
        chk_data = !v.exp_err;
        cur_err  = v.exp_err;
        mon_on   = 1'b1;

        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'(1));
        check("start_rdy", 32'(pix_rdy), 32'(1));
        check("start_err_clr", 32'(err), 32'(0));

        for (int p = 0; p < int'(IMG_W * IMG_H); p++) begin
            r = p / int'(IMG_W);
            c = p % int'(IMG_W);
            if (p == v.abort_at) begin
                mon_on  = 1'b0;
                pix_vld = 1'b0;
                RESET   = 1'b0;
                #1;
                check_all_zero("abort");
                tick();
                tick();
                check("abort_hold_vld", 32'(res_vld), 32'(0));
                RESET = 1'b1;
                repeat (SOBEL_LAT + 2) begin
                    tick();
                    check("abort_no_vld", 32'(res_vld), 32'(0));
                    check("abort_idle", 32'(busy), 32'(0));
                end
                return;
            end
            gap = 0;
            if (r == v.gap_row && c == v.gap_col) gap = v.gap_len;
            else if (v.kind == 1 && c == 0 && r > 0) gap = int'($urandom_range(0, 3));
            pix_vld = 1'b0;
            repeat (gap) tick();
            pix_vld = 1'b1;
            pix_in  = img[r][c];
            start   = v.start_mid && (r == 3) && (c == 0);
            acc = 1'b0;
            for (int w = 0; w < 8 && !acc; w++) begin
                if (pix_rdy) begin
                    acc = 1'b1;
                    last_acc = cyc;
                end
                tick();
                start = 1'b0;
            end
            if (!acc) fail("accept_timeout");
        end
        pix_vld = 1'b0;

        waitc = 0;
        while (n_done == 0 && waitc < 20) begin
            tick();
            waitc++;
        end
        if (n_done == 0) fail("done_timeout");
        repeat (3) tick();
        check("busy_after", 32'(busy), 32'(0));
        check("done_count", 32'(n_done), 32'(1));
        check("err_after", 32'(err), 32'(v.exp_err));
        if (chk_data) begin
            check("col_en_count", 32'(n_col), 32'(v.exp_col));
            check("res_vld_count", 32'(n_vld), 32'(v.exp_vld));
            check("res_last_count", 32'(n_last), 32'(1));
            check("model_empty", 32'(exp_q.size()), 32'(0));
        end
        mon_on = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, -1, 0, 0, 1'b0, -1, 1'b0, int'(N_COL), int'(N_VLD)};  // plain ramp
        vecs[1] = '{0,  3, 0, 5, 1'b0, -1, 1'b0, int'(N_COL), int'(N_VLD)};  // gap after col 7
        vecs[2] = '{0,  3, 4, 2, 1'b0, -1, 1'b1, int'(N_COL), int'(N_VLD)};  // gap mid-row
        vecs[3] = '{1, -1, 0, 0, 1'b1, -1, 1'b0, int'(N_COL), int'(N_VLD)};  // start in RUN
        vecs[4] = '{1, -1, 0, 0, 1'b0, 26, 1'b0, int'(N_COL), int'(N_VLD)};  // reset at row 3 col 2
        vecs[5] = '{0, -1, 0, 0, 1'b0, -1, 1'b0, int'(N_COL), int'(N_VLD)};  // restart after abort
        vecs[6] = '{1, -1, 0, 0, 1'b0, -1, 1'b0, int'(N_COL), int'(N_VLD)};  // random frame

        RESET = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        RESET = 1'b1;
        repeat (3) begin
            tick();
            check("post_reset_rdy", 32'(pix_rdy), 32'(0));
            check("post_reset_busy", 32'(busy), 32'(0));
        end

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i]);
            repeat (2) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/sobel_ctrl.md
SOBEL_CTRL -- requirements
Module: sobel_ctrl

Interface
REQ-001 Parameters, one per line:
- IMG_W, 64, pixels per row (>=3).
- IMG_H, 64, rows per frame (>=3).
- PIX_W, 8, pixel and result width.
- SOBEL_LAT, 3, cycles from a column presented to the sobel datapath until its result appears on sobel_ret.

REQ-002 Ports, one per line:
- CLOCK  in  1  single clock; all logic on its rising edge.
- RESET  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a frame.
- pix_in  in  PIX_W  raster-order input pixel.
- pix_vld  in  1  pix_in valid.
- pix_rdy  out  1  controller accepts a pixel; transfer occurs when pix_vld=1 and pix_rdy=1.
- input_row_a00  out  PIX_W  column pixel from row r-2, to the datapath.
- input_row_a01  out  PIX_W  column pixel from row r-1.
- input_row_a02  out  PIX_W  column pixel from row r (current).
- col_en  out  1  column outputs carry a newly accepted column.
- sobel_ret  in  PIX_W  datapath result.
- res_out  out  PIX_W  result forwarded from sobel_ret.
- res_vld  out  1  res_out is a valid interior-pixel result.
- res_last  out  1  final result of the frame; qualifies res_vld.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle end-of-frame pulse.
- err  out  1  sticky mid-row stall flag.

Function
REQ-003 The FSM SHALL have states IDLE, FILL, RUN, DRAIN and DONE.
REQ-004 State transitions:
- IDLE->FILL on start.
- FILL->RUN after the last pixel of row 1 is accepted.
- RUN->DRAIN after pixel (IMG_H-1, IMG_W-1) is accepted.
- DRAIN->DONE after SOBEL_LAT+1 cycles.
- DONE->IDLE after 1 cycle.
REQ-005 pix_rdy SHALL be 1 in FILL and RUN, and 0 in IDLE, DRAIN and DONE.
REQ-006 Counters col (0..IMG_W-1) and row (0..IMG_H-1) SHALL advance on each accepted pixel; col wraps to 0 and row increments at col=IMG_W-1.
REQ-007 Two line buffers (IMG_W x PIX_W) SHALL be updated on each accepted pixel at address col: lb0[col]<=lb1[col] and lb1[col]<=pix_in.
REQ-008 One cycle after an accepted pixel, a00/a01/a02 SHALL equal the old lb0[col], the old lb1[col] and pix_in, all registered; col_en SHALL be 1 on that cycle only for pixels accepted in RUN.
REQ-009 A column SHALL be tagged interior when row>=2 and col>=2; the tag SHALL be delayed by SOBEL_LAT cycles through a shift register to produce res_vld.
REQ-010 res_out SHALL equal sobel_ret on every cycle; only cycles with res_vld=1 are meaningful.
REQ-011 Exactly (IMG_W-2)*(IMG_H-2) res_vld pulses SHALL occur per frame; res_last SHALL accompany the last one.
REQ-012 done SHALL be 1 only in the DONE state.
REQ-013 Once a row's first pixel is accepted, pix_vld SHALL stay 1 until col=IMG_W-1.
REQ-014 A pix_vld=0 cycle while 0<col<IMG_W in FILL or RUN SHALL set err; err SHALL clear only on the next accepted start. The pixel stream still proceeds after an error, and its results are undefined.
REQ-015 Gaps between rows (col=0) SHALL be legal and SHALL NOT affect the results.
REQ-016 A start pulse while busy=1 SHALL be ignored.

Reset
REQ-017 While RESET=0: state=IDLE; all counters and the delay line cleared; every output 0, including err. Line-buffer contents are not reset.
REQ-018 Reset asserted mid-frame SHALL abort the frame immediately with no further res_vld; the next start SHALL produce a correct full frame.

Structure
REQ-019 Package sobel_pkg SHALL hold PIX_W, the default IMG_W/IMG_H/SOBEL_LAT values and the FSM state type.
REQ-020 The two line buffers and their shift-write logic SHALL be a sub-module sobel_linebuf. Counters, FSM, error check and the result-valid delay line remain in sobel_ctrl.

Verification (IMG_W=8, IMG_H=6, SOBEL_LAT=3)
REQ-021 Reset: RESET=0, then release -> all outputs 0 and busy=0; pix_rdy=0 until start.
REQ-022 Full frame: start, then 48 contiguous pixels -> col_en high 32 cycles; 24 res_vld pulses with res_last on the 24th; done once, SOBEL_LAT+1 cycles after the last accept plus 1.
REQ-023 Column data: pixel=row*16+col -> the col_en cycle for row 3, col 5 shows a00=0x15, a01=0x25, a02=0x35.
REQ-024 Stalls: 5-cycle pix_vld=0 gap after col 7 -> err=0 and results identical to REQ-022. A gap at col 4 -> err=1, held through DONE, cleared by the next start.
REQ-025 Mid-frame reset: RESET=0 at row 3, col 2 -> res_vld=0 that cycle and busy=0. Restart -> REQ-022 response.
REQ-026 start pulsed during RUN -> no effect on counters, res_vld count or done timing.
